step_sequencer: RTL
===================

// Module: step_sequencer
// PURPOSE
//  Drives the 4 coils of the unipolar stepper from the registered direction bit (direction_control.direction_out).
//  Generates a fixed step rate and walks an 8-entry half-step phase table.
//  Makes reversals safe: coils held, then a dwell period, then stepping resumes in the new direction.
//  Tracks a signed-free 16-bit position count for the display/readout logic.
// PARAMETERS
//  STEP_DIV      100000  clk cycles per step (>=2); 500 Hz step rate at 50 MHz
//  DWELL_CYCLES  25000   clk cycles coils are held before a reversal takes effect (>=1)
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous, active-low reset
//  enable        in   1   1 = motor runs; 0 = coils de-energised
//  direction_in  in   1   requested direction, 1 = CW, 0 = CCW
//  half_step     in   1   1 = half-step (index +/-1); 0 = full-step (index +/-2)
//  coil_out      out  4   coil drive {A,B,C,D}, registered
//  dir_active    out  1   direction currently applied to stepping
//  step_pulse    out  1   1-cycle strobe on each coil_out advance
//  reversing     out  1   high while in DWELL
//  position      out  16  half-step position count, wraps mod 2^16
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
//  Reset values:
//  - coil_out=0000, dir_active=1, step_pulse=0, reversing=0, position=0
//  - phase index=0, step timer=0, dwell timer=0, state IDLE
//  Phase table, index 0..7:
//  - 1000 1100 0100 0110 0010 0011 0001 1001
//  - Index arithmetic is 3-bit mod 8: CW adds, CCW subtracts.
//  - Full-step steps by 2, so index parity is preserved (even = wave drive, odd = two-phase on).
//  States:
//  - IDLE:
//    - coil_out=0000; dir_active<=direction_in every cycle; timers held at 0; index retained.
//    - enable=1 -> RUN. On the entry cycle coil_out<=table[index] and no step_pulse.
//  - RUN: step timer counts 0..STEP_DIV-1 then returns to 0. At terminal count:
//    - direction_in==dir_active:
//      - index += / -= step size; coil_out<=table[new index], visible the next cycle.
//      - step_pulse=1 for that one cycle.
//      - position +/- step size (1 or 2), CW increments.
//    - direction_in!=dir_active: no step -> DWELL, coils held, dwell timer=0.
//    - half_step is sampled only at terminal count; a mode change never alters coils mid-period.
//  - DWELL:
//    - reversing=1; coils held; counts DWELL_CYCLES cycles.
//    - At the end: dir_active<=direction_in (re-sampled), step timer=0 -> RUN.
//    - If the switch returned to the old direction, dir_active is unchanged; the same path applies.
//  Priority:
//  - enable=0 in any state -> IDLE the next cycle: coil_out=0000, reversing=0, step_pulse=0.
//  - enable=0 overrides a simultaneous terminal count, so no step occurs.
//  - position and index are never cleared except by reset.
//  - reset_n asserted mid-step or mid-dwell clears everything immediately (async); no partial step.
//  Wrap: position 16'hFFFF +1 -> 16'h0000; 16'h0000 -1 -> 16'hFFFF.
// TESTING (STEP_DIV=4, DWELL_CYCLES=3)
//  1. Reset, enable=1, dir=1, half=1:
//     - coil 1000 -> 1100 -> 0100 every 4 clks; step_pulse each time; position 1, 2.
//  2. Full-step CCW from index 0:
//     - coil 1000 -> 0001 -> 0010; position 0000 -> FFFE -> FFFC.
//  3. Flip direction_in while running:
//     - no step at next terminal count; reversing high exactly 3 clks.
//     - dir_active toggles; the first CCW step follows 4 clks later.
//  4. Flip and restore direction_in before the dwell ends:
//     - dwell completes, dir_active unchanged, stepping resumes in the original direction.
//  5. enable dropped on the terminal-count cycle:
//     - coil 0000 next cycle, no step_pulse, position unchanged.
//     - Re-enable restores the last table entry.
//  6. reset_n pulsed low mid-DWELL:
//     - all outputs at reset values asynchronously; dir_active=1.

Source files
------------

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: the motor controls going into the stepper sequencer and the coil/status signals coming out of it
//  master: drives enable, direction_in, half_step; reads coil_out, dir_active, step_pulse, reversing, position
//  slave : the sequencer side of the same signals
interface step_sequencer_if;
  logic        enable;
  logic        direction_in;
  logic        half_step;
  logic [3:0]  coil_out;
  logic        dir_active;
  logic        step_pulse;
  logic        reversing;
  logic [15:0] position;
  modport master (
    output enable, direction_in, half_step,
    input  coil_out, dir_active, step_pulse, reversing, position
  );
  modport slave (
    input  enable, direction_in, half_step,
    output coil_out, dir_active, step_pulse, reversing, position
  );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: half/full-step phase sequencer for a 4-coil unipolar stepper with a dwell on every reversal
//  clk, reset_n            : clock and asynchronous active-low reset
//  bus.enable              : 1 runs the motor, 0 de-energises the coils
//  bus.direction_in        : requested direction, 1 = CW
//  bus.half_step           : 1 steps the phase index by 1, 0 by 2
//  bus.coil_out {A,B,C,D}  : registered coil drive
//  bus.dir_active          : direction currently applied to stepping
//  bus.step_pulse          : one-cycle strobe with each coil advance
//  bus.reversing           : high while the coils are held before a reversal
//  bus.position            : half-step position count, wraps mod 2^16
module step_sequencer #(
  parameter int STEP_DIV     = 100000,
  parameter int DWELL_CYCLES = 25000
) (
  input logic             clk,
  input logic             reset_n,
  step_sequencer_if.slave bus
);
  localparam int SW = $clog2(STEP_DIV);
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  // index 0 sits in the low nibble
  localparam logic [31:0] PHASES = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                    4'b0110, 4'b0100, 4'b1100, 4'b1000};
  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
  state_t state, state_d;
  logic [2:0] idx, idx_d, stride, idx_next;
  logic [SW-1:0] step_cnt, step_cnt_d;
  logic [DW-1:0] dwell_cnt, dwell_cnt_d;
  logic [3:0] coil, coil_d;
  logic [15:0] pos, pos_d;
  logic dir, dir_d, pulse, pulse_d, tc, dwell_done, same;
  assign tc = step_cnt == SW'(STEP_DIV - 1);
  assign dwell_done = dwell_cnt == DW'(DWELL_CYCLES - 1);
  assign same = bus.direction_in == dir;
  assign stride = bus.half_step ? 3'd1 : 3'd2;
  assign idx_next = dir ? idx + stride : idx - stride;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
      coil      <= '0;
      pos       <= '0;
      dir       <= 1'b1;
      pulse     <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      step_cnt  <= step_cnt_d;
      dwell_cnt <= dwell_cnt_d;
      coil      <= coil_d;
      pos       <= pos_d;
      dir       <= dir_d;
      pulse     <= pulse_d;
    end
  always_comb
    state_d = !bus.enable     ? IDLE :
              state == IDLE   ? RUN :
              state == RUN    ? (tc && !same ? DWELL : RUN) :
              dwell_done      ? RUN : DWELL;
  // enable low wins over everything, including a coinciding terminal count
  always_comb begin
    idx_d       = idx;
    coil_d      = coil;
    pos_d       = pos;
    dir_d       = state == IDLE ? bus.direction_in : dir;
    pulse_d     = 1'b0;
    step_cnt_d  = '0;
    dwell_cnt_d = '0;
    if (!bus.enable)
      coil_d = '0;
    else if (state == IDLE)
      coil_d = PHASES[{idx, 2'b00} +: 4];
    else if (state == RUN) begin
      step_cnt_d = tc ? '0 : step_cnt + 1'b1;
      if (tc && same) begin
        idx_d   = idx_next;
        coil_d  = PHASES[{idx_next, 2'b00} +: 4];
        pos_d   = dir ? pos + 16'(stride) : pos - 16'(stride);
        pulse_d = 1'b1;
      end
    end else begin
      dwell_cnt_d = dwell_done ? '0 : dwell_cnt + 1'b1;
      dir_d       = dwell_done ? bus.direction_in : dir;
    end
  end
  assign bus.coil_out   = coil;
  assign bus.dir_active = dir;
  assign bus.step_pulse = pulse;
  assign bus.reversing  = state == DWELL;
  assign bus.position   = pos;
endmodule
